// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MULDIV_MADD_EN to enable MADD/MADDU (ops 6/7), which accumulate the product into HI/LO.
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt, r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_opnd, w_opnd_nxt, r_a_raw, w_a_raw_nxt;
  logic [W2-1:0]    r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt, r_done, w_done_nxt, r_dbz, w_dbz_nxt;
  logic             r_is_div, w_is_div_nxt, r_madd, w_madd_nxt, r_b_zero, w_b_zero_nxt;
  logic             r_neg_res, w_neg_res_nxt, r_neg_rem, w_neg_rem_nxt;

  // Operand decode and magnitude conversion for the request in IDLE
  logic             w_signed, w_is_mul, w_is_div, w_is_madd;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_signed  = ~op[0];
  assign w_is_mul  = (op[2:1] == 2'b00);
  assign w_is_div  = (op[2:1] == 2'b01);
  assign w_is_madd = MADD_EN && (op[2:1] == 2'b11);
  assign w_a_mag   = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag   = (w_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add multiply step: r_acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]  w_sum;
  logic [W2-1:0]   w_mul_acc;
  assign w_sum     = {1'b0, r_acc[W2-1:WIDTH]} + (WIDTH+1)'(r_acc[0] ? r_opnd : {WIDTH{1'b0}});
  assign w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: r_acc = {remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [W2-1:0]    w_div_acc;
  assign w_rem_sh  = r_acc[W2-1:WIDTH-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff    = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_acc = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  // Sign correction and final HI/LO value
  logic [WIDTH-1:0] w_quot, w_rem;
  logic [W2-1:0]    w_prod, w_res;
  assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];
  assign w_prod = (r_neg_res ? -r_acc : r_acc) + (r_madd ? {r_hi, r_lo} : {W2{1'b0}});
  assign w_res  = !r_is_div ? w_prod :
                  r_b_zero  ? {r_a_raw, {WIDTH{1'b1}}} : {w_rem, w_quot};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_a_raw   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_is_div  <= 1'b0;
      r_madd    <= 1'b0;
      r_b_zero  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_opnd    <= w_opnd_nxt;
      r_a_raw   <= w_a_raw_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_dbz     <= w_dbz_nxt;
      r_is_div  <= w_is_div_nxt;
      r_madd    <= w_madd_nxt;
      r_b_zero  <= w_b_zero_nxt;
      r_neg_res <= w_neg_res_nxt;
      r_neg_rem <= w_neg_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_opnd_nxt    = r_opnd;
    w_a_raw_nxt   = r_a_raw;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_dbz_nxt     = 1'b0;
    w_is_div_nxt  = r_is_div;
    w_madd_nxt    = r_madd;
    w_b_zero_nxt  = r_b_zero;
    w_neg_res_nxt = r_neg_res;
    w_neg_rem_nxt = r_neg_rem;
    case (r_state)
      S_IDLE: begin
        if (start && (w_is_mul || w_is_div || w_is_madd)) begin
          w_state_nxt   = S_CALC;
          w_busy_nxt    = 1'b1;
          w_cnt_nxt     = CW'(WIDTH);
          w_is_div_nxt  = w_is_div;
          w_madd_nxt    = w_is_madd;
          w_b_zero_nxt  = (b == '0);
          w_a_raw_nxt   = a;
          w_neg_res_nxt = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          w_neg_rem_nxt = w_signed && a[WIDTH-1];
          w_opnd_nxt    = w_is_div ? w_b_mag : w_a_mag;
          w_acc_nxt     = {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
        end else if (start && op == 3'd4) begin
          w_hi_nxt = a;
        end else if (start && op == 3'd5) begin
          w_lo_nxt = a;
        end
      end
      S_CALC: begin
        w_acc_nxt = r_is_div ? w_div_acc : w_mul_acc;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        {w_hi_nxt, w_lo_nxt} = w_res;
        w_done_nxt  = 1'b1;
        w_dbz_nxt   = r_is_div && r_b_zero;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
